// File: rtl/pulse_integrator_pkg.sv
// Shared types and helpers for the pulse integrator: FSM encoding,
// channel-index width and counter saturation value.
package pulse_integrator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones value for a counter of the given width (CNT_MAX source).
  function automatic logic [63:0] sat_value(input int width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/pulse_integrator_if.sv
// Readout port of the pulse integrator: one channel word per valid/ready beat.
interface pulse_integrator_if
  import pulse_integrator_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CHAN_W = chan_w(12)
);
  logic [DATA_W-1:0] out_data;
  logic [CHAN_W-1:0] out_channel;
  logic              out_overflow;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data, out_channel, out_overflow, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_channel, out_overflow, out_valid,
    output out_ready
  );
endinterface

// File: rtl/pulse_channel_counter.sv
// One channel: rising-edge detect, saturating window counter and sticky
// overflow. win_* expose the count including this cycle's edge for snapshots.
module pulse_channel_counter
  import pulse_integrator_pkg::*;
#(
  parameter int RESOLUTION = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pulse_in,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  keep_edge,
  output logic                  overflow,
  output logic [RESOLUTION-1:0] win_count,
  output logic                  win_overflow
);
  localparam logic [RESOLUTION-1:0] CNT_MAX = RESOLUTION'(sat_value(RESOLUTION));

  logic                  prev_q, prev_d;
  logic [RESOLUTION-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  edge_hit;

  always_comb begin
    prev_d       = pulse_in;
    edge_hit     = enable & pulse_in & ~prev_q;
    win_count    = cnt_q;
    win_overflow = ovf_q;
    if (edge_hit && (cnt_q != CNT_MAX)) begin
      win_count = cnt_q + RESOLUTION'(1);
    end
    if (win_count == CNT_MAX) begin
      win_overflow = 1'b1;
    end
    cnt_d = win_count;
    ovf_d = win_overflow;
    // When the closing snapshot is not taken, this cycle's edge opens the new window.
    if (clear) begin
      cnt_d = (keep_edge && edge_hit) ? RESOLUTION'(1) : '0;
      ovf_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: rtl/pulse_integrator.sv
// Per-channel pulse counting with strobe-triggered snapshot and serial
// valid/ready readout of the snapshot bank.
module pulse_integrator
  import pulse_integrator_pkg::*;
#(
  parameter int NUM_INPUTS = 12,
  parameter int RESOLUTION = 16,
  parameter int DROP_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  enable,
  input  logic                  integration_pulse,
  pulse_integrator_if.master    out_if,
  output logic [NUM_INPUTS-1:0] overflow,
  output logic                  busy,
  output logic [DROP_W-1:0]     dropped_frames
);
  localparam int CHAN_W = chan_w(NUM_INPUTS);
  localparam logic [CHAN_W-1:0] LAST_IDX = CHAN_W'(NUM_INPUTS - 1);

  logic [RESOLUTION-1:0] win_cnt [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] win_ovf;
  logic                  keep_edge;

  state_e                state_q, state_d;
  logic [CHAN_W-1:0]     idx_q, idx_d;
  logic [DROP_W-1:0]     dropped_q, dropped_d;
  logic [RESOLUTION-1:0] snap_q [NUM_INPUTS];
  logic [RESOLUTION-1:0] snap_d [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] snap_ovf_q, snap_ovf_d;

  assign keep_edge = (state_q == SEND);

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      pulse_channel_counter #(
        .RESOLUTION (RESOLUTION)
      ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in[gi]),
        .enable       (enable),
        .clear        (integration_pulse),
        .keep_edge    (keep_edge),
        .overflow     (overflow[gi]),
        .win_count    (win_cnt[gi]),
        .win_overflow (win_ovf[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dropped_d  = dropped_q;
    snap_d     = snap_q;
    snap_ovf_d = snap_ovf_q;
    case (state_q)
      IDLE: begin
        if (integration_pulse) begin
          state_d    = SEND;
          idx_d      = '0;
          snap_d     = win_cnt;
          snap_ovf_d = win_ovf;
        end
      end
      SEND: begin
        if (out_if.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CHAN_W'(1);
          end
        end
        // A strobe during readout loses its frame; the old snapshot keeps streaming.
        if (integration_pulse && (dropped_q != {DROP_W{1'b1}})) begin
          dropped_d = dropped_q + DROP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      dropped_q  <= '0;
      snap_ovf_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      dropped_q  <= dropped_d;
      snap_ovf_q <= snap_ovf_d;
      snap_q     <= snap_d;
    end
  end

  assign out_if.out_valid    = (state_q == SEND);
  assign out_if.out_data     = (state_q == SEND) ? snap_q[idx_q] : '0;
  assign out_if.out_channel  = (state_q == SEND) ? idx_q : '0;
  assign out_if.out_overflow = (state_q == SEND) ? snap_ovf_q[idx_q] : 1'b0;
  assign busy                = (state_q == SEND);
  assign dropped_frames      = dropped_q;

endmodule

// File: tb/tb_pulse_integrator.sv
// Bench for pulse_integrator: a 16-bit and a 4-bit instance share stimulus and
// are checked by a table, hand sequences and a window/queue reference model.
module tb_pulse_integrator;
  import pulse_integrator_pkg::*;

  localparam int N      = 12;
  localparam int RES    = 16;
  localparam int RES_S  = 4;
  localparam int DROP_W = 8;
  localparam int DROP_S = 2;
  localparam int CW     = chan_w(N);
  localparam int MAX16  = 65535;
  localparam int MAX_S  = 15;
  localparam int DMAX   = 255;
  localparam int DMAX_S = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, strobe, ready;
  logic [N-1:0]  pulse;
  logic [N-1:0]  ovf, ovf_s;
  logic          busy, busy_s;
  logic [DROP_W-1:0] drop;
  logic [DROP_S-1:0] drop_s;

  pulse_integrator_if #(.DATA_W(RES),   .CHAN_W(CW)) bus ();
  pulse_integrator_if #(.DATA_W(RES_S), .CHAN_W(CW)) bus_s ();
  assign bus.out_ready   = ready;
  assign bus_s.out_ready = ready;

  pulse_integrator #(.NUM_INPUTS(N), .RESOLUTION(RES), .DROP_W(DROP_W)) dut (
    .clk (clk), .rst_n (rst_n), .pulse_in (pulse), .enable (en),
    .integration_pulse (strobe), .out_if (bus), .overflow (ovf),
    .busy (busy), .dropped_frames (drop)
  );

  pulse_integrator #(.NUM_INPUTS(N), .RESOLUTION(RES_S), .DROP_W(DROP_S)) dut_s (
    .clk (clk), .rst_n (rst_n), .pulse_in (pulse), .enable (en),
    .integration_pulse (strobe), .out_if (bus_s), .overflow (ovf_s),
    .busy (busy_s), .dropped_frames (drop_s)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: raw edge totals per window plus a queue of pending words.
  typedef struct {
    int chan;
    int d16;
    bit o16;
    int ds;
    bit os;
  } word_t;

  int unsigned win [N];
  logic [N-1:0] prev_m;
  word_t        wq [$];
  int           drop_m, drop_ms;

  task automatic model_update();
    bit was_empty;
    int unsigned w;
    logic [N-1:0] hit;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) win[i] = 0;
      prev_m = '0;
      wq.delete();
      drop_m = 0;
      drop_ms = 0;
      return;
    end
    was_empty = (wq.size() == 0);
    if (!was_empty && ready) void'(wq.pop_front());
    hit = en ? (pulse & ~prev_m) : '0;
    for (int i = 0; i < N; i++) begin
      if (strobe) begin
        if (was_empty) begin
          w = win[i] + hit[i];
          wq.push_back('{i, (w > MAX16) ? MAX16 : int'(w), w >= MAX16,
                         (w > MAX_S) ? MAX_S : int'(w), w >= MAX_S});
          win[i] = 0;
        end else begin
          win[i] = hit[i];
        end
      end else begin
        win[i] = win[i] + hit[i];
      end
    end
    if (strobe && !was_empty) begin
      if (drop_m < DMAX) drop_m++;
      if (drop_ms < DMAX_S) drop_ms++;
    end
    prev_m = pulse;
  endtask

  task automatic model_check();
    logic [N-1:0] eo, eos;
    bit v;
    for (int i = 0; i < N; i++) begin
      eo[i]  = (win[i] >= MAX16);
      eos[i] = (win[i] >= MAX_S);
    end
    v = (wq.size() != 0);
    chk("m_valid", bus.out_valid, v);
    chk("m_valid_s", bus_s.out_valid, v);
    chk("m_busy", busy, v);
    chk("m_busy_s", busy_s, v);
    if (v) begin
      chk("m_chan", bus.out_channel, wq[0].chan);
      chk("m_data", bus.out_data, wq[0].d16);
      chk("m_ovf", bus.out_overflow, wq[0].o16);
      chk("m_chan_s", bus_s.out_channel, wq[0].chan);
      chk("m_data_s", bus_s.out_data, wq[0].ds);
      chk("m_ovf_s", bus_s.out_overflow, wq[0].os);
    end
    chk("m_overflow", ovf, eo);
    chk("m_overflow_s", ovf_s, eos);
    chk("m_dropped", drop, drop_m);
    chk("m_dropped_s", drop_s, drop_ms);
  endtask

  task automatic drive(input logic r, input logic [N-1:0] p, input logic e,
                       input logic s, input logic rd);
    rst_n = r; pulse = p; en = e; strobe = s; ready = rd;
    @(posedge clk);
    model_update();
    @(negedge clk);
    model_check();
  endtask

  int drained_data [N];
  int drained_n;

  task automatic drain(input string nm);
    drained_n = 0;
    for (int i = 0; i < N; i++) drained_data[i] = -1;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      if (bus.out_valid && int'(bus.out_channel) < N) begin
        drained_data[bus.out_channel] = int'(bus.out_data);
        drained_n++;
      end
      drive(1'b1, '0, 1'b1, 1'b0, 1'b1);
    end
    chk({nm, "_done"}, busy, 1'b0);
  endtask

  typedef struct {
    logic         rst_n;
    logic [N-1:0] pulse;
    logic         en, strobe, ready;
    logic         exp_valid, exp_busy;
    int           exp_chan, exp_data;
  } vec_t;

  vec_t vecs [$];

  function automatic void add_vec(logic r, logic [N-1:0] p, logic e, logic s, logic rd,
                                  logic ev, logic eb, int ec, int ed);
    vecs.push_back('{r, p, e, s, rd, ev, eb, ec, ed});
  endfunction

  int got_chan [$];

  initial begin
    rst_n = 1'b0; pulse = '0; en = 1'b0; strobe = 1'b0; ready = 1'b0;
    prev_m = '0; drop_m = 0; drop_ms = 0;
    for (int i = 0; i < N; i++) win[i] = 0;

    // Table: five ch3 pulses, strobe, full back-to-back readout.
    add_vec(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      add_vec(1'b1, 12'h008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      add_vec(1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    end
    add_vec(1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
    for (int j = 0; j < N; j++) begin
      if (j < N - 1) add_vec(1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, j + 1, (j + 1 == 3) ? 5 : 0);
      else           add_vec(1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst_n, vecs[k].pulse, vecs[k].en, vecs[k].strobe, vecs[k].ready);
      chk($sformatf("tbl%0d_valid", k), bus.out_valid, vecs[k].exp_valid);
      chk($sformatf("tbl%0d_busy", k), busy, vecs[k].exp_busy);
      if (vecs[k].exp_valid || !vecs[k].rst_n) begin
        chk($sformatf("tbl%0d_chan", k), bus.out_channel, vecs[k].exp_chan);
        chk($sformatf("tbl%0d_data", k), bus.out_data, vecs[k].exp_data);
      end
    end

    // Level held high is a single edge.
    for (int c = 0; c < 100; c++) drive(1'b1, 12'h001, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 12'h001, 1'b1, 1'b1, 1'b0);
    chk("level_ch0", bus.out_data, 16'd1);
    drain("level");

    // Saturation on the 4-bit instance.
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 12'h002, 1'b1, 1'b0, 1'b0);
      if (k == 14) chk("sat_ovf_before", ovf_s[1], 1'b0);
      if (k == 15) chk("sat_ovf_at15", ovf_s[1], 1'b1);
      drive(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    chk("sat_ovf_cleared", ovf_s[1], 1'b0);
    drive(1'b1, '0, 1'b1, 1'b0, 1'b1);
    chk("sat_chan", bus_s.out_channel, 4'd1);
    chk("sat_data_s", bus_s.out_data, 4'd15);
    chk("sat_oflag_s", bus_s.out_overflow, 1'b1);
    chk("sat_data16", bus.out_data, 16'd20);
    chk("sat_oflag16", bus.out_overflow, 1'b0);
    drain("sat");

    // Ready asserted one cycle in three: order and completeness.
    for (int c = 0; c < 30; c++) drive(1'b1, N'($urandom), 1'b1, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    got_chan.delete();
    for (int c = 0; c < 200; c++) begin
      logic rd;
      if (!busy) break;
      rd = (c % 3 == 2);
      if (bus.out_valid && rd) got_chan.push_back(int'(bus.out_channel));
      drive(1'b1, N'($urandom), 1'b1, 1'b0, rd);
    end
    chk("slow_done", busy, 1'b0);
    chk("slow_count", got_chan.size(), N);
    for (int i = 0; i < got_chan.size(); i++) chk($sformatf("slow_order%0d", i), got_chan[i], i);

    // Strobes during readout are dropped and clear the counters.
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 12'h004, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    chk("drop_one", drop, 8'd1);
    chk("drop_valid", bus.out_valid, 1'b1);
    chk("drop_chan", bus.out_channel, 4'd0);
    for (int k = 0; k < 3; k++) drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    chk("drop_four", drop, 8'd4);
    chk("drop_sat_s", drop_s, 2'd3);
    drive(1'b1, 12'h004, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
    drain("drop_old");
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    drain("drop_new");
    chk("drop_new_ch2", drained_data[2], 1);
    chk("drop_new_words", drained_n, N);

    // Edge coincident with the strobe belongs to the closing window.
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 12'h020, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 12'h000, 1'b1, 1'b0, 1'b0);
    end
    drive(1'b1, 12'h020, 1'b1, 1'b1, 1'b0);
    drain("coinc");
    chk("coinc_ch5", drained_data[5], 3);
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    drain("coinc_next");
    chk("coinc_next_ch5", drained_data[5], 0);

    // Dropped count is nonzero here; reset mid-readout clears everything.
    drive(1'b1, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, '0, 1'b1, 1'b1, 1'b1);
    drive(1'b1, '0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dropped", drop, 8'd0);
    chk("rst_dropped_s", drop_s, 2'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic r, e, s, rd;
      r  = ($urandom_range(0, 999) != 0);
      e  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 39) == 0);
      rd = ((c / 500) % 2 == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
      drive(r, N'($urandom & $urandom), e, s, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
